har_window_feeder: RTL
======================

// Module: har_window_feeder
// PURPOSE
// Upstream producer for the HAR memristor-crossbar classifier. Accepts a
// valid/ready stream of signed features, assembles one IMG_SIZE-sample window,
// pulses the crossbar reset, then drives image[] and V_valid. It captures
// predicted_class and returns it on a valid/ready result channel.
// PARAMETERS
// IMG_SIZE      95  features per window (classifier input length)
// M             15  feature MSB index; features are signed [M:0]
// NUM_CLASSES   6   class count; predicted_class range is 0..NUM_CLASSES-1
// CLASS_W       4   predicted_class width
// VALID_CYCLES  2   cycles V_valid is held high; must be >= 2
// PORTS
// clk              in   1        clock, rising edge
// rst              in   1        async active-low reset
// s_valid          in   1        feature stream valid
// s_ready          out  1        feature stream ready
// s_data           in   M+1      signed feature sample
// s_last           in   1        marks the last sample of a window
// image            out  [M:0]x IMG_SIZE  signed window to the classifier
// V_valid          out  1        classifier evaluate strobe
// mem_reset        out  1        one-cycle crossbar reset pulse per window
// predicted_class  in   CLASS_W  classifier result
// res_valid        out  1        result valid
// res_ready        in   1        result accepted
// res_class        out  CLASS_W  captured class
// res_error        out  1        window length was not IMG_SIZE
// win_count        out  16       completed windows, wraps at 2^16
// BEHAVIOUR
// - Reset: state=FILL, idx=0, all image entries=0. s_ready=1 (reflects FILL
//   state). V_valid=0, mem_reset=0, res_valid=0, res_class=0, res_error=0,
//   win_count=0.
// - Handshake: transfer when s_valid&s_ready (or res_valid&res_ready).
//   s_ready=1 only in FILL. res_valid holds until accepted.
//   res_class/res_error are stable while res_valid=1.
// - FILL: each transfer writes image[idx]=s_data and increments idx.
//   idx saturates at IMG_SIZE; transfers beyond that are dropped and set
//   err. A transfer with s_last ends the window: go to CLEAR, and
//   err |= (idx+1 != IMG_SIZE). Entries not written stay 0 (zero padding).
// - CLEAR: mem_reset=1 for exactly 1 cycle, then go to DRIVE.
// - DRIVE: V_valid=1 for VALID_CYCLES consecutive cycles; image is stable.
//   Then go to SETTLE.
// - SETTLE: 1 cycle with V_valid=0. At its closing edge: res_class <=
//   predicted_class, res_error <= err, res_valid <= 1. Go to RESULT.
//   The classifier derives its class from scores registered one edge
//   earlier, so VALID_CYCLES>=2 is required for a fresh result.
// - RESULT: wait for res_ready. On the handshake edge: res_valid<=0,
//   win_count++, all image entries cleared to 0, idx=0, err=0, go to FILL.
//   The first sample of the next window is accepted the following cycle.
// - image is stable from the end of FILL through the RESULT handshake.
// - Reset asserted mid-window: the partial window is discarded; the
//   all-zero reset state is entered asynchronously. No result is emitted.
// - s_valid with s_ready=0 is ignored; the upstream must hold the data.
// - Latency from the s_last transfer edge to res_valid=1 is
//   VALID_CYCLES+2 cycles (CLEAR + DRIVE + SETTLE).
// STRUCTURE
// - Shared package har_pkg: IMG_SIZE, M, NUM_CLASSES, CLASS_W constants and
//   the state enum {FILL, CLEAR, DRIVE, SETTLE, RESULT}.
// - One sub-module, har_sample_buffer: IMG_SIZE x (M+1) register array with
//   write index, write enable, saturation flag and synchronous clear-all.
// - FSM, V_valid counter and result registers stay in the top module.
// TESTING
// 1 Full window: 95 samples s_data=i-47, s_last on #95, res_ready=1 ->
//   mem_reset 1 cycle, V_valid 2 cycles, res_valid 4 cycles after s_last,
//   res_class=classifier output, res_error=0.
// 2 Short window: s_last on sample #10 -> image[10..94]=0, res_error=1.
// 3 Long window: 100 samples, s_last on #100 -> image=first 95,
//   samples 96..100 dropped, res_error=1.
// 4 Backpressure: res_ready=0 for 20 cycles -> res_valid/res_class held,
//   s_ready=0 throughout; on accept, win_count 0->1 and image all 0.
// 5 Reset mid-FILL after 40 samples -> all outputs at reset values,
//   no res_valid; next full window classifies correctly.
// 6 Stream gaps: s_valid toggled randomly -> same res_class as scenario 1;
//   force win_count=16'hFFFF, complete a window -> 0.

Source files
------------

// File: rtl/har_pkg.sv
// Shared constants, FSM state encoding and small helpers for the HAR
// crossbar window feeder.
package har_pkg;

    localparam int IMG_SIZE     = 95;
    localparam int M            = 15;
    localparam int NUM_CLASSES  = 6;
    localparam int CLASS_W      = 4;
    localparam int VALID_CYCLES = 2;
    localparam int IDX_W        = $clog2(IMG_SIZE + 1);
    localparam int VCNT_W       = $clog2(VALID_CYCLES + 1);

    typedef enum logic [2:0] {
        FILL   = 3'd0,
        CLEAR  = 3'd1,
        DRIVE  = 3'd2,
        SETTLE = 3'd3,
        RESULT = 3'd4
    } state_e;

    // True when a window closed by the sample at write slot idx is not IMG_SIZE long.
    function automatic logic win_len_bad(input logic [IDX_W-1:0] idx);
        return ((IDX_W+1)'(idx) + (IDX_W+1)'(1)) != (IDX_W+1)'(IMG_SIZE);
    endfunction

endpackage

// File: rtl/har_sample_buffer.sv
// Window register array: sequential write with a saturating index and a
// synchronous clear of every entry.
module har_sample_buffer
    import har_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic                clr,
    input  logic signed [M:0]   din,
    output logic signed [M:0]   image [IMG_SIZE],
    output logic [IDX_W-1:0]    idx,
    output logic                full
);

    logic signed [M:0] image_q [IMG_SIZE];
    logic signed [M:0] image_d [IMG_SIZE];
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic              full_s;

    assign full_s = (idx_q == IDX_W'(IMG_SIZE));

    // Next array contents: clear wins over write, writes past the end are dropped.
    always_comb begin
        image_d = image_q;
        idx_d   = idx_q;
        if (clr) begin
            for (int k = 0; k < IMG_SIZE; k++) begin
                image_d[k] = '0;
            end
            idx_d = '0;
        end else if (we && !full_s) begin
            image_d[idx_q] = din;
            idx_d          = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Array and index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < IMG_SIZE; k++) begin
                image_q[k] <= '0;
            end
            idx_q <= '0;
        end else begin
            image_q <= image_d;
            idx_q   <= idx_d;
        end
    end

    assign image = image_q;
    assign idx   = idx_q;
    assign full  = full_s;

endmodule

// File: rtl/har_window_feeder.sv
// Collects one feature window, sequences the crossbar (reset pulse, evaluate
// strobe, settle) and hands the captured class back on a result channel.
module har_window_feeder
    import har_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [M:0]    s_data,
    input  logic                 s_last,
    output logic signed [M:0]    image [IMG_SIZE],
    output logic                 V_valid,
    output logic                 mem_reset,
    input  logic [CLASS_W-1:0]   predicted_class,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CLASS_W-1:0]   res_class,
    output logic                 res_error,
    output logic [15:0]          win_count
);

    state_e              state_q, state_d;
    logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
    logic                err_q, err_d;
    logic                s_ready_q, s_ready_d;
    logic                v_valid_q, v_valid_d;
    logic                mem_reset_q, mem_reset_d;
    logic                res_valid_q, res_valid_d;
    logic [CLASS_W-1:0]  res_class_q, res_class_d;
    logic                res_error_q, res_error_d;
    logic [15:0]         win_count_q, win_count_d;
    logic                buf_we_s, buf_clr_s, buf_full_s;
    logic [IDX_W-1:0]    buf_idx_s;
    logic                s_xfer_s, r_xfer_s;

    assign s_xfer_s = s_valid && s_ready_q;
    assign r_xfer_s = res_valid_q && res_ready;

    har_sample_buffer u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we_s),
        .clr   (buf_clr_s),
        .din   (s_data),
        .image (image),
        .idx   (buf_idx_s),
        .full  (buf_full_s)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            vcnt_q      <= '0;
            err_q       <= 1'b0;
            s_ready_q   <= 1'b1;
            v_valid_q   <= 1'b0;
            mem_reset_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            res_error_q <= 1'b0;
            win_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            vcnt_q      <= vcnt_d;
            err_q       <= err_d;
            s_ready_q   <= s_ready_d;
            v_valid_q   <= v_valid_d;
            mem_reset_q <= mem_reset_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            res_error_q <= res_error_d;
            win_count_q <= win_count_d;
        end
    end

    // Next-state logic, window error tracking and buffer control.
    always_comb begin
        state_d   = state_q;
        vcnt_d    = vcnt_q;
        err_d     = err_q;
        buf_we_s  = 1'b0;
        buf_clr_s = 1'b0;
        case (state_q)
            FILL: begin
                if (s_xfer_s) begin
                    buf_we_s = 1'b1;
                    err_d    = err_q | buf_full_s | (s_last && win_len_bad(buf_idx_s));
                    state_d  = s_last ? CLEAR : FILL;
                end else begin
                    state_d = FILL;
                end
            end
            CLEAR: begin
                vcnt_d  = '0;
                state_d = DRIVE;
            end
            DRIVE: begin
                if (vcnt_q == VCNT_W'(VALID_CYCLES - 1)) begin
                    state_d = SETTLE;
                end else begin
                    vcnt_d = vcnt_q + VCNT_W'(1);
                end
            end
            SETTLE: begin
                state_d = RESULT;
            end
            RESULT: begin
                if (r_xfer_s) begin
                    buf_clr_s = 1'b1;
                    err_d     = 1'b0;
                    state_d   = FILL;
                end else begin
                    state_d = RESULT;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Output register inputs: strobes decoded from the upcoming state.
    always_comb begin
        s_ready_d   = (state_d == FILL);
        v_valid_d   = (state_d == DRIVE);
        mem_reset_d = (state_d == CLEAR);
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        res_error_d = res_error_q;
        win_count_d = win_count_q;
        if (state_q == SETTLE) begin
            res_valid_d = 1'b1;
            res_class_d = predicted_class;
            res_error_d = err_q;
        end else if (state_q == RESULT && r_xfer_s) begin
            res_valid_d = 1'b0;
            win_count_d = win_count_q + 16'd1;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    assign s_ready   = s_ready_q;
    assign V_valid   = v_valid_q;
    assign mem_reset = mem_reset_q;
    assign res_valid = res_valid_q;
    assign res_class = res_class_q;
    assign res_error = res_error_q;
    assign win_count = win_count_q;

endmodule
